// File: rtl/imem_arb_pkg.sv
// Shared types and default sizes for the instruction-RAM port arbiter.
package imem_arb_pkg;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_LANES  = 4;

  typedef enum logic {ST_BOOT, ST_RUN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_L} owner_e;
endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating counter of consecutive loader denials; at_limit forces the loader through.
module imem_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && !at_limit_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of a single-port, read-first, 1-cycle-latency instruction RAM.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int BOOT_EN      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                l_req,
  input  logic                l_we,
  input  logic [DATA_W/8-1:0] l_be,
  input  logic [ADDR_W-1:0]   l_addr,
  input  logic [DATA_W-1:0]   l_wdata,
  output logic                l_gnt,
  output logic                l_rvalid,
  output logic [DATA_W-1:0]   l_rdata,
  input  logic                load_done,
  output logic                booting,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic [DATA_W/8-1:0] ram_we,
  input  logic [DATA_W-1:0]   ram_dout
);
  localparam int LANES = DATA_W / 8;

  state_e state_q;
  owner_e own_q, own_d;
  logic   at_limit;
  logic   starve_inc;

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (state_q == ST_BOOT)  l_gnt = l_req;
      else if (l_req && at_limit) l_gnt = 1'b1;
      else if (f_req)          f_gnt = 1'b1;
      else if (l_req)          l_gnt = 1'b1;
    end
  end

  // Idle cycles still present f_addr: a stray read is harmless and keeps the mux small.
  assign ram_addr = l_gnt ? l_addr : f_addr;
  assign ram_din  = l_wdata;
  assign ram_we   = {LANES{l_gnt & l_we}} & l_be;

  always_comb begin
    own_d = OWN_NONE;
    if (f_gnt)              own_d = OWN_F;
    else if (l_gnt && !l_we) own_d = OWN_L;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (BOOT_EN != 0) ? ST_BOOT : ST_RUN;
      own_q   <= OWN_NONE;
    end else begin
      own_q <= own_d;
      if (state_q == ST_BOOT && load_done) state_q <= ST_RUN;
    end
  end

  assign starve_inc = (state_q == ST_RUN) && l_req && !l_gnt;

  imem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (starve_inc),
    .clr_i      (!starve_inc),
    .at_limit_o (at_limit)
  );

  assign f_rvalid = (own_q == OWN_F);
  assign l_rvalid = (own_q == OWN_L);
  assign f_rdata  = ram_dout;
  assign l_rdata  = ram_dout;
  assign booting  = (state_q == ST_BOOT);
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter with a RAM and a behavioural arbiter model.
module tb_imem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NL = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, l_req, l_we, load_done;
  logic [AW-1:0] f_addr, l_addr;
  logic [NL-1:0] l_be;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, booting;
  logic [DW-1:0] f_rdata, l_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [NL-1:0] ram_we;

  logic          f_gnt0, f_rvalid0, l_gnt0, l_rvalid0, booting0;
  logic [DW-1:0] f_rdata0, l_rdata0, ram_din0;
  logic [DW-1:0] ram_dout0 = '0;
  logic [AW-1:0] ram_addr0;
  logic [NL-1:0] ram_we0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .BOOT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .load_done(load_done), .booting(booting),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .BOOT_EN(0)) dut0 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt0), .f_rvalid(f_rvalid0), .f_rdata(f_rdata0),
    .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt0), .l_rvalid(l_rvalid0), .l_rdata(l_rdata0),
    .load_done(load_done), .booting(booting0),
    .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_we(ram_we0), .ram_dout(ram_dout0)
  );

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 16) return 32'h11223344;
    return (32'(i) * 32'h01030507) ^ 32'hA5A50000;
  endfunction

  // RAM seen by the DUT: registered, read-first, byte-lane writes.
  logic [DW-1:0] ram  [0:(1<<AW)-1];
  // Model's own view of memory contents.
  logic [DW-1:0] mmem [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = init_word(i);
      mmem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    ram_dout <= ram[ram_addr];
    for (int i = 0; i < NL; i++)
      if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: boot flag, count of consecutive loader denials, pending read owner/data.
  bit            m_boot = 1'b1;
  int            m_den  = 0;
  int            m_own  = 0;
  logic [DW-1:0] m_data;

  always @(negedge clk) begin
    bit            eg_f, eg_l;
    logic [AW-1:0] eaddr;
    logic [NL-1:0] ewe;
    eg_f = 1'b0;
    eg_l = 1'b0;
    if (!rst) begin
      if (m_boot)                  eg_l = l_req;
      else if (l_req && m_den >= SL) eg_l = 1'b1;
      else if (f_req)              eg_f = 1'b1;
      else if (l_req)              eg_l = 1'b1;
    end
    eaddr = eg_l ? l_addr : f_addr;
    ewe   = (eg_l && l_we) ? l_be : '0;
    chk("f_gnt",    32'(f_gnt),    32'(eg_f));
    chk("l_gnt",    32'(l_gnt),    32'(eg_l));
    chk("ram_addr", 32'(ram_addr), 32'(eaddr));
    chk("ram_we",   32'(ram_we),   32'(ewe));
    chk("ram_din",  ram_din,       l_wdata);
    chk("f_rvalid", 32'(f_rvalid), 32'(m_own == 1));
    chk("l_rvalid", 32'(l_rvalid), 32'(m_own == 2));
    if (m_own == 1) chk("f_rdata", f_rdata, m_data);
    if (m_own == 2) chk("l_rdata", l_rdata, m_data);
    chk("booting",  32'(booting),  32'(m_boot));

    if (rst) begin
      m_boot = 1'b1;
      m_den  = 0;
      m_own  = 0;
    end else begin
      m_own = 0;
      if (eg_f) begin
        m_own  = 1;
        m_data = mmem[f_addr];
      end else if (eg_l && !l_we) begin
        m_own  = 2;
        m_data = mmem[l_addr];
      end
      if (eg_l && l_we)
        for (int i = 0; i < NL; i++)
          if (l_be[i]) mmem[l_addr][8*i +: 8] = l_wdata[8*i +: 8];
      if (!m_boot && l_req && !eg_l) m_den = (m_den < SL) ? m_den + 1 : SL;
      else                           m_den = 0;
      if (m_boot && load_done) m_boot = 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; load_done = 1'b0;
    f_addr = '0; l_addr = '0; l_be = '0; l_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; f_req = 1'b1; f_addr = 9'h000;

    @(negedge clk);
    chk("rst_booting", 32'(booting), 32'd1);
    chk("rst_rvalid",  32'({f_rvalid, l_rvalid}), 32'd0);
    chk("b0_booting",  32'(booting0), 32'd0);
    chk("b0_fgnt",     32'(f_gnt0), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if (c != 0) begin
        next_cycle();
        @(negedge clk);
      end
      chk("boot_fgnt",   32'(f_gnt), 32'd0);
      chk("boot_rvalid", 32'(f_rvalid), 32'd0);
    end

    next_cycle();
    f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_be = 4'b0101;
    l_addr = 9'h010; l_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("boot_we",  32'(ram_we), 32'h5);
    chk("boot_wgnt", 32'(l_gnt), 32'd1);

    next_cycle();
    l_we = 1'b0; l_be = '0;
    @(negedge clk);
    chk("boot_rgnt", 32'(l_gnt), 32'd1);

    next_cycle();
    load_done = 1'b1;
    @(negedge clk);
    chk("ld_lgnt",    32'(l_gnt), 32'd1);
    chk("wr_rvalid",  32'(l_rvalid), 32'd1);
    chk("wr_rdback",  l_rdata, 32'h11BB33DD);

    next_cycle();
    load_done = 1'b0; l_req = 1'b0; f_req = 1'b1; f_addr = 9'h000;
    @(negedge clk);
    chk("run_booting", 32'(booting), 32'd0);
    chk("ld_rvalid",   32'(l_rvalid), 32'd1);
    chk("ld_rdata",    l_rdata, 32'h11BB33DD);

    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) f_req = 1'b0;
      else        f_addr = 9'(k + 1);
      @(negedge clk);
      chk("b2b_rvalid", 32'(f_rvalid), 32'd1);
      chk("b2b_rdata",  f_rdata, init_word(k));
    end

    next_cycle();
    f_req = 1'b1; f_addr = 9'h005; l_req = 1'b1; l_we = 1'b0; l_addr = 9'h007;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("starve_lgnt", 32'(l_gnt), 32'(c == 5));
      chk("starve_fgnt", 32'(f_gnt), 32'(c != 5));
      next_cycle();
    end
    l_req = 1'b0;

    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fgnt", 32'(f_gnt), 32'd0);
    next_cycle();
    rst = 1'b0; f_req = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_to_boot",   32'(booting), 32'd1);

    for (int c = 0; c < 600; c++) begin
      next_cycle();
      rst       = ($urandom_range(0, 99) == 0);
      load_done = ($urandom_range(0, 19) == 0);
      f_req     = ($urandom_range(0, 3) != 0);
      l_req     = ($urandom_range(0, 1) == 1);
      l_we      = ($urandom_range(0, 1) == 1);
      l_be      = 4'($urandom_range(0, 15));
      f_addr    = 9'($urandom_range(0, 15));
      l_addr    = 9'($urandom_range(0, 15));
      l_wdata   = $urandom;
    end
    next_cycle();
    rst = 1'b0; f_req = 1'b0; l_req = 1'b0; load_done = 1'b0;
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
